// File: rtl/iq_decim_accum.sv
// ---------------------------------------------------------------------------
// iq_decim_accum
//   Decimating I/Q block accumulator. Sums DECIM consecutive signed I and Q
//   samples and presents each completed block sum on a valid/ready style
//   output register. A new block sum that lands on an unaccepted result
//   replaces it and raises the sticky overrun flag.
//
// Parameters
//   IN_W   signed input sample width
//   DECIM  samples per output block (power of two, 2..16)
//   OUT_W  derived: IN_W + log2(DECIM). A full-scale block cannot overflow.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset, overrides every other input
//   sample_en  one-cycle strobe qualifying i_in / q_in
//   i_in,q_in  signed input samples
//   restart    drop the partial block; the output side is untouched
//   clr_ovr    clear the sticky overrun flag (a same-cycle set wins)
//   out_valid  i_out / q_out hold a completed block sum
//   out_ready  consumer accepts the current result
//   i_out,q_out signed block sums
//   overrun    sticky: an unaccepted result was overwritten
// ---------------------------------------------------------------------------
module iq_decim_accum #(
  parameter int IN_W  = 8,
  parameter int DECIM = 4,
  localparam int CNT_W = $clog2(DECIM),
  localparam int OUT_W = IN_W + CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_en,
  input  logic signed [IN_W-1:0]  i_in,
  input  logic signed [IN_W-1:0]  q_in,
  input  logic                    restart,
  input  logic                    clr_ovr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    overrun
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]        cnt_r;
  logic signed [OUT_W-1:0] acc_i_r;
  logic signed [OUT_W-1:0] acc_q_r;
  state_t                  state_r;
  logic                    out_valid_r;
  logic signed [OUT_W-1:0] i_out_r;
  logic signed [OUT_W-1:0] q_out_r;
  logic                    overrun_r;

  logic signed [OUT_W-1:0] ext_i_s;
  logic signed [OUT_W-1:0] ext_q_s;
  logic signed [OUT_W-1:0] sum_i_s;
  logic signed [OUT_W-1:0] sum_q_s;
  logic                    take_s;
  logic                    blk_done_s;
  logic                    ovr_set_s;

  // Sign-extended running sums and block-completion decode.
  always_comb begin
    ext_i_s    = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};
    ext_q_s    = {{(OUT_W-IN_W){q_in[IN_W-1]}}, q_in};
    sum_i_s    = acc_i_r + ext_i_s;
    sum_q_s    = acc_q_r + ext_q_s;
    // restart discards a same-cycle sample entirely
    take_s     = sample_en & ~restart;
    blk_done_s = take_s & (cnt_r == CNT_LAST);
    if (state_r == ST_FULL) begin
      ovr_set_s = blk_done_s & ~out_ready;
    end else begin
      ovr_set_s = 1'b0;
    end
  end

  // Input side: sample counter and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else if (restart) begin
      cnt_r   <= '0;
      acc_i_r <= '0;
      acc_q_r <= '0;
    end else if (take_s) begin
      if (cnt_r == CNT_LAST) begin
        // block complete: sum goes to the output registers, start fresh
        cnt_r   <= '0;
        acc_i_r <= '0;
        acc_q_r <= '0;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
        acc_i_r <= sum_i_s;
        acc_q_r <= sum_q_s;
      end
    end else begin
      cnt_r   <= cnt_r;
      acc_i_r <= acc_i_r;
      acc_q_r <= acc_q_r;
    end
  end

  // Output side: EMPTY/FULL state machine with registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      i_out_r     <= '0;
      q_out_r     <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (blk_done_s) begin
            state_r     <= ST_FULL;
            out_valid_r <= 1'b1;
            i_out_r     <= sum_i_s;
            q_out_r     <= sum_q_s;
          end
        end
        ST_FULL: begin
          if (blk_done_s) begin
            // new sum replaces the held one whether or not it was accepted
            state_r     <= ST_FULL;
            out_valid_r <= 1'b1;
            i_out_r     <= sum_i_s;
            q_out_r     <= sum_q_s;
          end else if (out_ready) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun flag; a set in the same cycle as clr_ovr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_r <= 1'b1;
    end else if (clr_ovr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign out_valid = out_valid_r;
  assign i_out     = i_out_r;
  assign q_out     = q_out_r;
  assign overrun   = overrun_r;

endmodule

// File: doc/iq_decim_accum.md
IQ_DECIM_ACCUM -- requirements
Module: iq_decim_accum

Interface
REQ-001 SHALL have parameter IN_W, default 8: signed I/Q sample width.
REQ-002 SHALL have parameter DECIM, default 4: samples per output; power of 2, range 2..16.
REQ-003 SHALL derive OUT_W = IN_W + log2(DECIM), so full-scale sums never overflow.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_en  in  1  one-cycle sample strobe from the ADC-ready edge detector.
REQ-007 i_in  in  IN_W  signed I sample; valid only when sample_en=1.
REQ-008 q_in  in  IN_W  signed Q sample; valid only when sample_en=1.
REQ-009 restart  in  1  abandons the current partial block.
REQ-010 clr_ovr  in  1  clears the overrun flag.
REQ-011 out_valid  out  1  i_out/q_out hold a completed block sum.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 i_out  out  OUT_W  signed sum of DECIM I samples.
REQ-014 q_out  out  OUT_W  signed sum of DECIM Q samples.
REQ-015 overrun  out  1  sticky: an unaccepted result was overwritten.

Function
REQ-016 SHALL keep sample counter cnt (0..DECIM-1) and signed OUT_W accumulators acc_i and acc_q.
- Inputs are sign-extended before adding.
REQ-017 On sample_en with cnt<DECIM-1: SHALL add the inputs to the accumulators and increment cnt.
REQ-018 On sample_en with cnt=DECIM-1 (block complete):
- SHALL load acc + input into the output registers.
- SHALL clear the accumulators and set cnt to 0, in the same cycle.
REQ-019 Latency: out_valid and the new sums SHALL appear on the first rising edge after the block-completing sample_en.
REQ-020 Output FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY -> FULL on block complete.
- FULL -> EMPTY on out_ready with no block complete that cycle.
- FULL stays FULL on block complete (with or without out_ready).
REQ-021 i_out and q_out SHALL stay stable while out_valid=1 and out_ready=0, unless an overrun occurs.
REQ-022 Block complete while FULL and out_ready=0:
- SHALL overwrite the outputs with the new sums.
- SHALL set overrun=1.
REQ-023 Block complete while FULL and out_ready=1: SHALL load the new sums, keep out_valid=1, and leave overrun unchanged.
REQ-024 out_ready while EMPTY SHALL have no effect.
REQ-025 restart:
- SHALL clear cnt and both accumulators next cycle.
- SHALL NOT affect out_valid, i_out, q_out or overrun.
REQ-026 restart and sample_en in the same cycle: restart SHALL win and the sample SHALL be discarded.
REQ-027 overrun SHALL stay set until reset or clr_ovr.
- A set and clr_ovr in the same cycle SHALL leave overrun=1 (set wins).
REQ-028 sample_en SHALL be accepted on consecutive cycles with no gap required.

Reset
REQ-029 reset=1 on a clock edge SHALL force:
- cnt=0, acc_i=acc_q=0
- out_valid=0, i_out=q_out=0, overrun=0
REQ-030 reset SHALL take priority over every other input, including mid-block and while FULL.
- The partial block and any pending output are discarded.
REQ-031 The first sample_en after reset deasserts SHALL be sample 0 of a new block.

Verification (IN_W=8, DECIM=4, OUT_W=10)
REQ-032 Basic sum:
- Stimulus: I=1,2,3,4 and Q=-1,-2,-3,-4 on four sample_en pulses, out_ready=1.
- Response: one cycle after the 4th pulse, out_valid=1, i_out=10, q_out=-10; out_valid=0 the following cycle.
REQ-033 Extremes:
- Stimulus: I=-128 x4, Q=127 x4.
- Response: i_out=-512, q_out=508, no wrap.
REQ-034 Backpressure overrun:
- Stimulus: out_ready=0; block A (I=1 x4), then block B (I=2 x4).
- Response: i_out=4 held after A; after B, i_out=8 and overrun=1; clr_ovr pulse -> overrun=0.
REQ-035 Simultaneous accept and new result:
- Stimulus: out_ready=1 in the same cycle block B completes while FULL.
- Response: out_valid stays 1, i_out=new sum, overrun=0.
REQ-036 Restart mid-block:
- Stimulus: I=5,5; then restart together with a sample_en (I=7); then I=1,1,1,1.
- Response: single result i_out=4.
REQ-037 Reset mid-operation:
- Stimulus: reset after 2 samples while FULL.
- Response: out_valid=0, overrun=0; the next 4 samples (I=3 x4) give i_out=12.
